// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
// Holds the reset PC default, the instruction field positions used by fetch
// and PC sequencing, the NOP encoding and the fetch FSM state encoding.
package mips_pkg;

    // Base of the text segment; the PC is loaded with this value on reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    // Instruction field positions.
    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 26;
    localparam int IMM16_MSB    = 15;
    localparam int IMM16_LSB    = 0;
    localparam int TARGET26_MSB = 25;
    localparam int TARGET26_LSB = 0;

    // sll $0,$0,0 encodes as all zeros; used as the reset value of the
    // instruction register.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Fetch/execute sequencing states.
    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc_i            current PC
//   instr_field_i   instruction bits [25:0] (target26 / imm16 fields)
//   rs_data_i       register-file rs value, jr target
//   branch_eq_i     beq decode
//   branch_ne_i     bne decode
//   jump_signal_i   j/jal decode
//   jump_reg_i      jr decode
//   zero_i          ALU zero flag
//   pc_plus4_o      pc_i + 4
//   next_pc_o       selected next PC (jr > j > taken branch > pc+4)
//   misalign_o      jr selected with a target whose bits [1:0] are nonzero
module pc_next_sel
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [25:0]           instr_field_i,
    input  logic [DATA_WIDTH-1:0] rs_data_i,
    input  logic                  branch_eq_i,
    input  logic                  branch_ne_i,
    input  logic                  jump_signal_i,
    input  logic                  jump_reg_i,
    input  logic                  zero_i,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    output logic [DATA_WIDTH-1:0] next_pc_o,
    output logic                  misalign_o
);

    logic [DATA_WIDTH-1:0] branch_offset;
    logic [DATA_WIDTH-1:0] branch_target;
    logic [DATA_WIDTH-1:0] jump_target;
    logic [DATA_WIDTH-1:0] jr_target;
    logic                  branch_taken;

    assign pc_plus4_o = pc_i + DATA_WIDTH'(4);

    // Word offset: sign-extend imm16 and scale by 4.
    assign branch_offset = {{(DATA_WIDTH-18){instr_field_i[IMM16_MSB]}},
                            instr_field_i[IMM16_MSB:IMM16_LSB], 2'b00};
    assign branch_target = pc_plus4_o + branch_offset;

    // Pseudo-direct jump keeps the region bits of pc+4.
    assign jump_target = {pc_plus4_o[DATA_WIDTH-1:28],
                          instr_field_i[TARGET26_MSB:TARGET26_LSB], 2'b00};

    // jr silently word-aligns its target; the misalignment is reported.
    assign jr_target  = {rs_data_i[DATA_WIDTH-1:2], 2'b00};
    assign misalign_o = jump_reg_i & (|rs_data_i[1:0]);

    // beq and bne together is not a legal decode; the OR falls out naturally.
    assign branch_taken = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);

    // NOTE: every output of a combinational block gets a default first so a
    // missed branch can never infer a latch.
    always_comb begin
        next_pc_o = pc_plus4_o;
        if (jump_reg_i) begin
            next_pc_o = jr_target;
        end else if (jump_signal_i) begin
            next_pc_o = jump_target;
        end else if (branch_taken) begin
            next_pc_o = branch_target;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch and PC-sequencing stage of the single-cycle MIPS core.
// Two-state sequencer: FETCH requests the word at pc_o until memory is
// ready, EXEC presents the captured instruction for one cycle and loads
// the next PC at its end.
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   imem_req_o/addr_o      fetch request and address (address = pc_o)
//   imem_ready_i/rdata_i   memory response
//   branch_eq_i, branch_ne_i, jump_signal_i, jump_reg_i, zero_i, rs_data_i
//                          next-PC controls, sampled only in EXEC
//   instr_o, opcode_o      current instruction and its opcode field
//   instr_valid_o          high in EXEC; datapath commits this cycle
//   pc_o, pc_plus4_o       current PC and its link value
//   addr_err_o             sticky jr misalignment flag
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ready_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  branch_eq_i,
    input  logic                  branch_ne_i,
    input  logic                  jump_signal_i,
    input  logic                  jump_reg_i,
    input  logic                  zero_i,
    input  logic [DATA_WIDTH-1:0] rs_data_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [5:0]            opcode_o,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    output logic                  addr_err_o
);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  addr_err_q, addr_err_d;
    logic [DATA_WIDTH-1:0] next_pc;
    logic                  misalign;

    pc_next_sel #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_pc_next_sel (
        .pc_i          (pc_q),
        .instr_field_i (instr_q[25:0]),
        .rs_data_i     (rs_data_i),
        .branch_eq_i   (branch_eq_i),
        .branch_ne_i   (branch_ne_i),
        .jump_signal_i (jump_signal_i),
        .jump_reg_i    (jump_reg_i),
        .zero_i        (zero_i),
        .pc_plus4_o    (pc_plus4_o),
        .next_pc_o     (next_pc),
        .misalign_o    (misalign)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        addr_err_d = addr_err_q;
        unique case (state_q)
            FETCH: begin
                if (imem_ready_i) begin
                    instr_d = imem_rdata_i;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                pc_d       = next_pc;
                addr_err_d = addr_err_q | misalign;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Request is masked during reset so memory never sees a fetch that the
    // stage is about to discard.
    assign imem_req_o    = (state_q == FETCH) && !reset_i;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (state_q == EXEC);
    assign instr_o       = instr_q;
    assign opcode_o      = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign pc_o          = pc_q;
    assign addr_err_o    = addr_err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, random
// instruction stream against an arithmetic next-PC model, and hand-written
// reset sequences.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic        branch_eq_i, branch_ne_i, jump_signal_i, jump_reg_i, zero_i;
    logic [31:0] rs_data_i;
    logic [31:0] instr_o;
    logic [5:0]  opcode_o;
    logic        instr_valid_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        addr_err_o;

    instruction_fetch dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rdata_i  (imem_rdata_i),
        .branch_eq_i   (branch_eq_i),
        .branch_ne_i   (branch_ne_i),
        .jump_signal_i (jump_signal_i),
        .jump_reg_i    (jump_reg_i),
        .zero_i        (zero_i),
        .rs_data_i     (rs_data_i),
        .instr_o       (instr_o),
        .opcode_o      (opcode_o),
        .instr_valid_o (instr_valid_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .addr_err_o    (addr_err_o)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] model_pc;
    logic        model_err;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        int          waits;
        logic        beq, bne, j, jr, zero;
        logic [31:0] rs;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Next PC from the instruction-set rules, in plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr,
                                               input logic beq, input logic bne, input logic j,
                                               input logic jr, input logic zero,
                                               input logic [31:0] rs);
        logic [31:0] p4;
        int          off;
        p4  = pc + 32'd4;
        off = int'($signed(instr[15:0]));
        if (jr) return rs - (rs % 32'd4);
        if (j) return (p4 & 32'hF000_0000) + 32'(instr[25:0]) * 32'd4;
        if ((beq && zero) || (bne && !zero)) return p4 + 32'(off * 4);
        return p4;
    endfunction

    // Control inputs are don't-care outside EXEC; keep them moving.
    task automatic drive_noise();
        branch_eq_i   = 1'($urandom);
        branch_ne_i   = 1'($urandom);
        jump_signal_i = 1'($urandom);
        jump_reg_i    = 1'($urandom);
        zero_i        = 1'($urandom);
        rs_data_i     = $urandom;
    endtask

    task automatic do_reset();
        reset_i      = 1'b1;
        imem_ready_i = 1'($urandom);
        imem_rdata_i = $urandom;
        drive_noise();
        #1 check("req low in reset", 32'(imem_req_o), 32'd0);
        repeat (2) begin
            @(posedge clk_i);
            @(negedge clk_i);
        end
        check("reset pc", pc_o, RST_PC);
        check("reset valid", 32'(instr_valid_o), 32'd0);
        check("reset err", 32'(addr_err_o), 32'd0);
        check("reset instr", instr_o, 32'd0);
        reset_i      = 1'b0;
        imem_ready_i = 1'b0;
        #1;
        check("req after reset", 32'(imem_req_o), 32'd1);
        check("addr after reset", imem_addr_o, RST_PC);
        model_pc  = RST_PC;
        model_err = 1'b0;
    endtask

    // One fetch/execute pair. Entered and left just after a falling edge.
    task automatic run_instr(input string tag, input logic [31:0] instr, input int waits,
                             input logic beq, input logic bne, input logic j, input logic jr,
                             input logic zero, input logic [31:0] rs,
                             input logic [31:0] exp_pc, input logic exp_err);
        check({tag, " fetch req"}, 32'(imem_req_o), 32'd1);
        check({tag, " fetch addr"}, imem_addr_o, model_pc);
        check({tag, " fetch valid"}, 32'(instr_valid_o), 32'd0);
        for (int w = 0; w < waits; w++) begin
            imem_ready_i = 1'b0;
            imem_rdata_i = $urandom;
            drive_noise();
            @(posedge clk_i);
            @(negedge clk_i);
            check({tag, " wait addr"}, imem_addr_o, model_pc);
            check({tag, " wait req"}, 32'(imem_req_o), 32'd1);
            check({tag, " wait valid"}, 32'(instr_valid_o), 32'd0);
        end
        imem_ready_i = 1'b1;
        imem_rdata_i = instr;
        drive_noise();
        @(posedge clk_i);
        @(negedge clk_i);
        check({tag, " exec valid"}, 32'(instr_valid_o), 32'd1);
        check({tag, " exec req"}, 32'(imem_req_o), 32'd0);
        check({tag, " exec instr"}, instr_o, instr);
        check({tag, " exec opcode"}, 32'(opcode_o), 32'(instr[31:26]));
        check({tag, " exec pc"}, pc_o, model_pc);
        check({tag, " exec pc+4"}, pc_plus4_o, model_pc + 32'd4);
        branch_eq_i   = beq;
        branch_ne_i   = bne;
        jump_signal_i = j;
        jump_reg_i    = jr;
        zero_i        = zero;
        rs_data_i     = rs;
        imem_ready_i  = 1'($urandom);
        imem_rdata_i  = $urandom;
        @(posedge clk_i);
        @(negedge clk_i);
        imem_ready_i = 1'b0;
        drive_noise();
        check({tag, " next pc"}, pc_o, exp_pc);
        check({tag, " err"}, 32'(addr_err_o), 32'(exp_err));
        check({tag, " valid drop"}, 32'(instr_valid_o), 32'd0);
        model_pc = exp_pc;
    endtask

    initial begin
        logic [31:0] ins, rs, exp;
        logic        beq, bne, j, jr, zero;
        int          waits;

        reset_i      = 1'b1;
        imem_ready_i = 1'b0;
        imem_rdata_i = 32'd0;
        drive_noise();
        model_pc  = RST_PC;
        model_err = 1'b0;

        //            rst   instr         w  beq  bne  j    jr   zero rs            exp_pc        err
        vecs[0]  = '{1'b1, 32'h0000_0000, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0040_0004,1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0000, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0040_0008,1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0000, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0040_000C,1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0000, 3, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0040_0004,1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0000, 3, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0040_0008,1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0000, 3, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0040_000C,1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0000, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0040_0004,1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 1, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0040_0008,1'b0};
        vecs[8]  = '{1'b0, 32'h1000_FFFF, 0, 1'b1,1'b0,1'b0,1'b0,1'b1,32'h0,        32'h0040_0008,1'b0};
        vecs[9]  = '{1'b0, 32'h1400_0004, 2, 1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0040_001C,1'b0};
        vecs[10] = '{1'b1, 32'h0000_0000, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0040_0004,1'b0};
        vecs[11] = '{1'b0, 32'h0000_0000, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0040_0008,1'b0};
        vecs[12] = '{1'b0, 32'h1000_FFFF, 0, 1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0040_000C,1'b0};
        vecs[13] = '{1'b1, 32'h0810_0010, 0, 1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0040_0040,1'b0};
        vecs[14] = '{1'b0, 32'h0810_0010, 1, 1'b0,1'b0,1'b1,1'b1,1'b0,32'h0040_0103,32'h0040_0100,1'b1};
        vecs[15] = '{1'b0, 32'h0000_0000, 2, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0040_0104,1'b1};
        vecs[16] = '{1'b0, 32'h1000_0010, 0, 1'b1,1'b1,1'b0,1'b0,1'b1,32'h0,        32'h0040_0148,1'b1};

        @(negedge clk_i);
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].rst) do_reset();
            run_instr($sformatf("vec%0d", i), vecs[i].instr, vecs[i].waits,
                      vecs[i].beq, vecs[i].bne, vecs[i].j, vecs[i].jr, vecs[i].zero,
                      vecs[i].rs, vecs[i].exp_pc, vecs[i].exp_err);
        end

        // Sticky error clears only on reset.
        do_reset();
        check("err cleared by reset", 32'(addr_err_o), 32'd0);

        // Random stream against the model.
        for (int i = 0; i < 60; i++) begin
            if (i == 30) do_reset();
            ins   = $urandom;
            waits = $urandom_range(0, 3);
            beq   = 1'($urandom);
            bne   = 1'($urandom);
            j     = ($urandom_range(0, 3) == 0);
            jr    = ($urandom_range(0, 4) == 0);
            zero  = 1'($urandom);
            rs    = $urandom;
            if ($urandom_range(0, 1) == 0) rs[1:0] = 2'b00;
            exp       = model_next(model_pc, ins, beq, bne, j, jr, zero, rs);
            model_err = model_err | (jr && (rs[1:0] != 2'b00));
            run_instr($sformatf("rnd%0d", i), ins, waits, beq, bne, j, jr, zero, rs, exp, model_err);
        end

        // Reset arriving in the second wait cycle with a late ready.
        do_reset();
        run_instr("pre-abort", 32'hABCD_1234, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                  32'h0040_0004, 1'b0);
        imem_ready_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort wait1 valid", 32'(instr_valid_o), 32'd0);
        reset_i      = 1'b1;
        imem_ready_i = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        #1 check("abort req low", 32'(imem_req_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort instr", instr_o, 32'd0);
        check("abort pc", pc_o, RST_PC);
        check("abort valid", 32'(instr_valid_o), 32'd0);
        reset_i      = 1'b0;
        imem_ready_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort post valid", 32'(instr_valid_o), 32'd0);
        check("abort post addr", imem_addr_o, RST_PC);
        model_pc  = RST_PC;
        model_err = 1'b0;
        run_instr("post-abort", 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                  32'h0040_0004, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch and PC-sequencing stage of the single-cycle MIPS core. Holds the program counter and fetches one instruction word from instruction memory over a req/ready handshake. It presents the instruction, including the opcode field that drives the control unit, for exactly one execute cycle. At the end of that cycle it computes the next PC from the control unit's branch/jump outputs, the ALU zero flag and the register-file rs value.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction word
- RESET_PC, 32'h0040_0000, PC value loaded by reset (text segment base)

Ports:
- clk_i  in  1  core clock; all state updates on rising edge
- reset_i  in  1  reset; synchronous, active-high
- imem_req_o  out  1  fetch request to instruction memory
- imem_addr_o  out  DATA_WIDTH  fetch address; equals pc_o
- imem_ready_i  in  1  memory returns imem_rdata_i this cycle
- imem_rdata_i  in  DATA_WIDTH  fetched instruction word
- branch_eq_i  in  1  control unit beq
- branch_ne_i  in  1  control unit bne
- jump_signal_i  in  1  control unit j/jal
- jump_reg_i  in  1  jr decode, from ALU control
- zero_i  in  1  ALU zero flag
- rs_data_i  in  DATA_WIDTH  register-file rs value, jr target
- instr_o  out  DATA_WIDTH  current instruction
- opcode_o  out  6  instr_o[31:26], to control unit
- instr_valid_o  out  1  high in EXEC; datapath commits this cycle
- pc_o  out  DATA_WIDTH  address of current instruction
- pc_plus4_o  out  DATA_WIDTH  pc_o + 4, jal link value
- addr_err_o  out  1  sticky; jr target had nonzero bits [1:0]

## Operation
- FSM states: FETCH, EXEC.
- FETCH:
  - imem_req_o=1 and imem_addr_o=pc_o, held stable until imem_ready_i=1.
  - When imem_ready_i=1, capture imem_rdata_i into instr_o and go to EXEC.
  - Any number of wait cycles is allowed, including zero (ready in the first FETCH cycle).
- EXEC:
  - instr_valid_o=1 and imem_req_o=0; imem_ready_i is ignored.
  - On the clock edge, load PC with next_pc and go to FETCH.
- next_pc priority, first match wins:
  1. jump_reg_i: {rs_data_i[31:2], 2'b00}. If rs_data_i[1:0]≠0, set addr_err_o.
  2. jump_signal_i: {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. Taken branch, defined as (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i): pc_plus4 + (sext(instr[15:0]) << 2), 32-bit, wrap-around ignored.
  4. Otherwise: pc_plus4.
- branch_eq_i and branch_ne_i both high is illegal; the behaviour is the OR given in rule 3.
- Control inputs are sampled only in EXEC. They are don't-care in FETCH.
- addr_err_o clears only on reset.

## Timing
- Reset values: state=FETCH, pc_o=RESET_PC, instr_o=0, instr_valid_o=0, addr_err_o=0.
  - imem_req_o rises in the first cycle after reset deasserts.
- Latency with zero-wait memory is 2 cycles per instruction. Each memory wait cycle adds 1.
- pc_o/imem_addr_o change only on the EXEC→FETCH edge or on reset.
- instr_o changes only on the FETCH→EXEC edge or on reset.
- opcode_o is combinational from instr_o; there is no extra cycle to the control unit.
- Reset has priority over every event, including mid-wait and mid-EXEC:
  - no PC update, no instruction capture;
  - imem_req_o deasserts while reset_i is high;
  - a late imem_ready_i in the reset cycle is discarded.

## Structure
- Shared package mips_pkg: RESET_PC default, opcode field position [31:26], imm16 and target26 field positions, NOP encoding (32'h0), FSM state encoding.
- Sub-module pc_next_sel: combinational next-PC mux, adders and misalignment detect, instantiated once.
- The FSM, PC register and instruction register stay in instruction_fetch.

## Test plan
- Reset: assert reset_i 2 cycles → pc_o=0x00400000, instr_valid_o=0, addr_err_o=0. Cycle after release: imem_req_o=1, imem_addr_o=0x00400000.
- Sequential fetch: 0-wait memory for 3 instructions → pc_o steps 0x00400000, 0x00400004, 0x00400008, one instr_valid_o pulse every 2 cycles. Repeat with 3 wait cycles → pulse every 5 cycles, address stable throughout each wait.
- Branch:
  - beq at 0x00400008, imm=0xFFFF, zero_i=1 → next pc_o=0x00400008.
  - Same instruction with zero_i=0 → next pc_o=0x0040000C.
  - bne, imm=0x0004, zero_i=0 → next pc_o=0x0040001C.
- Jump: j 0x08100010 at 0x00400000 → next pc_o=0x00400040, pc_plus4_o=0x00400004 during EXEC.
- jr precedence and error:
  - jump_reg_i=1 and jump_signal_i=1, rs_data_i=0x00400103 → next pc_o=0x00400100, addr_err_o=1 and stays 1.
  - Apply reset → addr_err_o=0.
- Reset mid-operation: assert reset_i during a 2nd wait cycle with imem_ready_i=1 in that cycle → instr_o=0, pc_o=0x00400000, instr_valid_o never pulses for the aborted fetch.
